// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - control-word pipeline from decode to write-back
// Stall holds, per-stage flush bubbles, valid-gated write strobes and occupancy/bubble stats.
module ctrl_pipe_stage #(
    parameter int                 CTRL_W      = 10,
    parameter int                 DEPTH       = 3,
    parameter logic [CTRL_W-1:0]  NOP_CTRL    = '0,
    parameter int                 MEMAREG_BIT = 6,
    parameter int                 ESCRREG_BIT = 5,
    parameter int                 CNT_W       = 16,
    localparam int                OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              valid_in,
    input  logic              stall,
    input  logic [DEPTH-1:0]  flush,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              valid_out,
    output logic              MemaReg,
    output logic              EscrReg,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [CTRL_W-1:0] r_ctrl  [DEPTH];
    logic              r_valid [DEPTH];
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [CTRL_W-1:0] w_src_ctrl  [DEPTH];
    logic              w_src_valid [DEPTH];
    logic [OCC_W-1:0]  w_occ;

    // Invalid entries are canonicalised to NOP_CTRL so a bubble can never carry a strobe.
    always_comb begin
        w_src_ctrl[0]  = valid_in ? ctrl_in : NOP_CTRL;
        w_src_valid[0] = valid_in;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_ctrl[i]  = r_ctrl[i-1];
            w_src_valid[i] = r_valid[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i]  <= NOP_CTRL;
                r_valid[i] <= 1'b0;
            end
            r_bubble_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush[i]) begin
                    r_ctrl[i]  <= NOP_CTRL;
                    r_valid[i] <= 1'b0;
                end else if (!stall) begin
                    r_ctrl[i]  <= w_src_ctrl[i];
                    r_valid[i] <= w_src_valid[i];
                end
            end
            if (!stall && !r_valid[DEPTH-1] && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign ctrl_out   = r_ctrl[DEPTH-1];
    assign valid_out  = r_valid[DEPTH-1];
    assign MemaReg    = r_valid[DEPTH-1] & r_ctrl[DEPTH-1][MEMAREG_BIT];
    assign EscrReg    = r_valid[DEPTH-1] & r_ctrl[DEPTH-1][ESCRREG_BIT];
    assign occupancy  = w_occ;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// tb/tb_ctrl_pipe_stage.sv - randomized model-checked bench for ctrl_pipe_stage
module tb_ctrl_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ctrl_in;
    logic        valid_in;
    logic        stall;
    logic [2:0]  flush3;
    logic [0:0]  flush1;

    logic [9:0]  ctrl_out3, ctrl_out1;
    logic        valid_out3, valid_out1;
    logic        mema3, mema1, escr3, escr1;
    logic [1:0]  occ3;
    logic [0:0]  occ1;
    logic [3:0]  bcnt3, bcnt1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_pipe_stage #(.CTRL_W(10), .DEPTH(3), .NOP_CTRL(10'h000), .MEMAREG_BIT(6),
                      .ESCRREG_BIT(5), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall), .flush(flush3), .ctrl_out(ctrl_out3), .valid_out(valid_out3),
        .MemaReg(mema3), .EscrReg(escr3), .occupancy(occ3), .bubble_cnt(bcnt3)
    );

    ctrl_pipe_stage #(.CTRL_W(10), .DEPTH(1), .NOP_CTRL(10'h000), .MEMAREG_BIT(6),
                      .ESCRREG_BIT(5), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall), .flush(flush1), .ctrl_out(ctrl_out1), .valid_out(valid_out1),
        .MemaReg(mema1), .EscrReg(escr1), .occupancy(occ1), .bubble_cnt(bcnt1)
    );

    // Reference: each pipe is a list of {valid, ctrl} entries, index 0 = youngest.
    int         dep [2] = '{3, 1};
    logic [10:0] m   [2][8];
    int          mb  [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) m[k][j] = 11'h000;
            mb[k] = 0;
        end
    endfunction

    function automatic void model_step(int k, logic [9:0] ci, logic vi, logic st, logic [7:0] fl);
        logic [10:0] nxt [8];
        int d = dep[k];
        for (int j = 0; j < 8; j++) nxt[j] = m[k][j];
        if (!st) begin
            if (!m[k][d-1][10]) mb[k] = (mb[k] >= 15) ? 15 : mb[k] + 1;
            for (int j = d - 1; j >= 1; j--) nxt[j] = m[k][j-1];
            nxt[0] = vi ? {1'b1, ci} : 11'h000;
        end
        for (int j = 0; j < d; j++) if (fl[j]) nxt[j] = 11'h000;
        for (int j = 0; j < 8; j++) m[k][j] = nxt[j];
    endfunction

    function automatic int model_occ(int k);
        int n = 0;
        for (int j = 0; j < dep[k]; j++) n += int'(m[k][j][10]);
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else begin
            model_step(0, ctrl_in, valid_in, stall, {5'b0, flush3});
            model_step(1, ctrl_in, valid_in, stall, {7'b0, flush1});
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [10:0] e3, e1;
            e3 = m[0][2];
            e1 = m[1][0];
            chk("ctrl_out3", 32'(ctrl_out3), 32'(e3[9:0]));
            chk("valid_out3", 32'(valid_out3), 32'(e3[10]));
            chk("mema3", 32'(mema3), 32'(e3[10] & e3[6]));
            chk("escr3", 32'(escr3), 32'(e3[10] & e3[5]));
            chk("occ3", 32'(occ3), 32'(model_occ(0)));
            chk("bcnt3", 32'(bcnt3), 32'(mb[0]));
            chk("ctrl_out1", 32'(ctrl_out1), 32'(e1[9:0]));
            chk("valid_out1", 32'(valid_out1), 32'(e1[10]));
            chk("mema1", 32'(mema1), 32'(e1[10] & e1[6]));
            chk("escr1", 32'(escr1), 32'(e1[10] & e1[5]));
            chk("occ1", 32'(occ1), 32'(model_occ(1)));
            chk("bcnt1", 32'(bcnt1), 32'(mb[1]));
        end
    end

    task automatic cyc(logic [9:0] ci, logic vi, logic st, logic [2:0] f3, logic f1);
        ctrl_in  = ci;
        valid_in = vi;
        stall    = st;
        flush3   = f3;
        flush1   = f1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1; ctrl_in = '0; valid_in = 1'b0; stall = 1'b0; flush3 = '0; flush1 = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ctrl_out", 32'(ctrl_out3), 32'h0);
        chk("rst_valid_out", 32'(valid_out3), 32'h0);
        chk("rst_occ", 32'(occ3), 32'h0);
        chk("rst_bcnt", 32'(bcnt3), 32'h0);
        chk_en = 1'b1;
        reset = 1'b0;

        // single valid word, latency 3
        cyc(10'h060, 1, 0, 0, 0);
        cyc(10'h000, 0, 0, 0, 0);
        cyc(10'h000, 0, 0, 0, 0);
        chk("t1_ctrl_out", 32'(ctrl_out3), 32'h060);
        chk("t1_mema", 32'(mema3), 32'h1);
        chk("t1_escr", 32'(escr3), 32'h1);
        cyc(10'h000, 0, 0, 0, 0);
        chk("t1_after_valid", 32'(valid_out3), 32'h0);
        chk("t1_after_mema", 32'(mema3), 32'h0);

        // stream A,B,C then stall
        cyc(10'h041, 1, 0, 0, 0);
        cyc(10'h022, 1, 0, 0, 0);
        cyc(10'h013, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(10'h3FF, 1, 1, 0, 0);
        chk("t2_frozen", 32'(ctrl_out3), 32'h041);
        chk("t2_occ", 32'(occ3), 32'h3);
        cyc(10'h000, 0, 0, 0, 0);
        chk("t2_B", 32'(ctrl_out3), 32'h022);
        cyc(10'h000, 0, 0, 0, 0);
        chk("t2_C", 32'(ctrl_out3), 32'h013);

        // full pipe, flush stages 0 and 1
        cyc(10'h061, 1, 0, 0, 0);
        cyc(10'h062, 1, 0, 0, 0);
        cyc(10'h063, 1, 0, 0, 0);
        cyc(10'h064, 1, 0, 3'b011, 0);
        chk("t3_occ", 32'(occ3), 32'h1);
        chk("t3_ctrl", 32'(ctrl_out3), 32'h062);
        cyc(10'h000, 0, 0, 0, 0);
        cyc(10'h000, 0, 0, 0, 0);
        chk("t3_valid", 32'(valid_out3), 32'h0);
        chk("t3_mema", 32'(mema3), 32'h0);

        // invalid entry canonicalised
        cyc(10'h3FF, 0, 0, 0, 0);
        cyc(10'h000, 0, 0, 0, 0);
        cyc(10'h000, 0, 0, 0, 0);
        chk("t4_ctrl", 32'(ctrl_out3), 32'h000);
        chk("t4_escr", 32'(escr3), 32'h0);

        // stall + flush on the output stage
        cyc(10'h071, 1, 0, 0, 0);
        cyc(10'h072, 1, 0, 0, 0);
        cyc(10'h073, 1, 0, 0, 0);
        cyc(10'h074, 1, 1, 3'b100, 1);
        chk("t7_occ", 32'(occ3), 32'h2);
        chk("t7_valid", 32'(valid_out3), 32'h0);
        chk("t7_d1_valid", 32'(valid_out1), 32'h0);
        cyc(10'h075, 1, 0, 0, 1);
        chk("t7_d1_flush", 32'(valid_out1), 32'h0);

        // idle saturation
        for (int i = 0; i < 20; i++) cyc(10'h000, 0, 0, 0, 0);
        chk("t5_sat", 32'(bcnt3), 32'hF);
        cyc(10'h000, 0, 0, 0, 0);
        chk("t5_hold", 32'(bcnt3), 32'hF);

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f;
            f = 3'(($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0);
            cyc(10'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                f, 1'($urandom_range(0, 9) == 0));
        end

        // asynchronous reset between edges
        cyc(10'h051, 1, 0, 0, 0);
        cyc(10'h052, 1, 0, 0, 0);
        cyc(10'h053, 1, 0, 0, 0);
        chk("t6_pre_occ", 32'(occ3), 32'h3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_occ", 32'(occ3), 32'h0);
        chk("t6_valid", 32'(valid_out3), 32'h0);
        chk("t6_bcnt", 32'(bcnt3), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(10'h000, 0, 0, 0, 0);
        cyc(10'h000, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
